// File: rtl/delay_line_var.sv
// delay_line_var: multi-channel, stall-able delay line with runtime tap select.
// CHANNELS lanes of DATA_WIDTH bits travel together through MAX_DELAY stages.
// The tap is chosen by delay_sel, clamped to 1..MAX_DELAY.
// A per-stage valid bit and a saturating fill counter report when the tap
// holds real data.
// Build option: define DELAY_LINE_VAR_CLEAR_DATA_EN to make reset and flush
// also zero the data stages. When it is left undefined, the data stages have
// no reset term, so the line can map onto shift-register primitives.
module delay_line_var #(
    parameter int DATA_WIDTH = 8,
    parameter int CHANNELS   = 4,
    parameter int MAX_DELAY  = 8,
    parameter int SEL_W      = $clog2(MAX_DELAY + 1)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic                           flush,
    input  logic [SEL_W-1:0]               delay_sel,
    input  logic                           valid_in,
    input  logic [CHANNELS*DATA_WIDTH-1:0] Data_In,
    output logic [CHANNELS*DATA_WIDTH-1:0] Data_Out,
    output logic                           valid_out,
    output logic                           primed
);

    localparam int W     = CHANNELS * DATA_WIDTH;
    localparam int IDX_W = $clog2(MAX_DELAY);

    // All channels share one stage word, so they can never reorder or mix.
    logic [MAX_DELAY-1:0][W-1:0] stage;
    logic [MAX_DELAY-1:0]        vld;
    logic [SEL_W-1:0]            fill_cnt;
    logic [SEL_W-1:0]            eff;
    logic [IDX_W-1:0]            tap;

    // Clamp the requested delay: 0 acts as 1, and anything past the end acts as MAX_DELAY.
    always_comb begin
        eff = delay_sel;
        if (delay_sel == '0)
            eff = SEL_W'(1);
        else if (delay_sel > SEL_W'(MAX_DELAY))
            eff = SEL_W'(MAX_DELAY);
    end

    assign tap = IDX_W'(eff - SEL_W'(1));

    // Valid pipeline and fill counter. Flush wins over enable and drops the
    // incoming sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld      <= '0;
            fill_cnt <= '0;
        end else if (flush) begin
            vld      <= '0;
            fill_cnt <= '0;
        end else if (enable) begin
            vld <= {vld[MAX_DELAY-2:0], valid_in};
            if (fill_cnt != SEL_W'(MAX_DELAY))
                fill_cnt <= fill_cnt + SEL_W'(1);
        end
    end

`ifdef DELAY_LINE_VAR_CLEAR_DATA_EN
    // Data stages: cleared by reset and flush, so Data_Out reads 0 until real data reaches the tap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stage <= '0;
        else if (flush)
            stage <= '0;
        else if (enable)
            stage <= {stage[MAX_DELAY-2:0], Data_In};
    end
`else
    // Data stages: plain enabled shift with no clear, so stale data stays visible after a flush.
    always_ff @(posedge clk) begin
        if (enable && !flush)
            stage <= {stage[MAX_DELAY-2:0], Data_In};
    end
`endif

    // Data_Out is forced to 0 while reset is held. Un-reset stages then never
    // leak onto the output during reset.
    assign Data_Out  = reset ? stage[tap] : '0;
    assign valid_out = vld[tap];
    assign primed    = (fill_cnt >= eff);

endmodule

// File: tb/tb_delay_line_var.sv
// tb_delay_line_var: random and directed stimulus checked against a
// queue-based model of the delay line. The driver pushes the expected outputs
// for each cycle, and a negedge monitor pops and compares them.
module tb_delay_line_var;

    localparam int DW = 8;
    localparam int CH = 4;
    localparam int MD = 8;
    localparam int SW = $clog2(MD + 1);
    localparam int W  = DW * CH;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic          flush = 1'b0;
    logic          valid_in = 1'b0;
    logic [SW-1:0] delay_sel = '0;
    logic [W-1:0]  Data_In = '0;
    logic [W-1:0]  Data_Out;
    logic          valid_out;
    logic          primed;

    delay_line_var #(.DATA_WIDTH(DW), .CHANNELS(CH), .MAX_DELAY(MD)) dut (
        .clk(clk), .reset(reset), .enable(enable), .flush(flush),
        .delay_sel(delay_sel), .valid_in(valid_in), .Data_In(Data_In),
        .Data_Out(Data_Out), .valid_out(valid_out), .primed(primed)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [W-1:0] d; logic v; } ent_t;
    typedef struct packed { logic [W-1:0] d; logic v; logic p; logic chk_d; } exp_t;

    // Model: the history of accepted samples, newest first, plus a count of
    // enabled shifts since the last clear.
    ent_t hist[$];
    int   fill = 0;
    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int eff_of(input int s);
        if (s == 0) return 1;
        if (s > MD) return MD;
        return s;
    endfunction

    // Monitor: compare one expected entry against the DUT outputs before each rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("valid_out", W'(valid_out), W'(e.v));
            check("primed", W'(primed), W'(e.p));
            if (e.chk_d) check("Data_Out", Data_Out, e.d);
        end
    end

    // One clock: drive the inputs, predict the outputs, then advance the model at the edge.
    task automatic step(input bit en, input bit fl, input bit vin, input logic [W-1:0] din, input int sel);
        exp_t e;
        ent_t x;
        int   k;
        enable = en; flush = fl; valid_in = vin; Data_In = din; delay_sel = SW'(sel);
        k = eff_of(sel);
        e.d = '0; e.v = 1'b0; e.p = (fill >= k);
        if (k - 1 < hist.size()) begin
            e.d = hist[k-1].d;
            e.v = hist[k-1].v;
        end
`ifdef DELAY_LINE_VAR_CLEAR_DATA_EN
        e.chk_d = 1'b1;
`else
        e.chk_d = (k - 1 < hist.size());
`endif
        exp_q.push_back(e);
        @(posedge clk);
        if (fl) begin
            foreach (hist[i]) begin
                hist[i].v = 1'b0;
`ifdef DELAY_LINE_VAR_CLEAR_DATA_EN
                hist[i].d = '0;
`endif
            end
            fill = 0;
        end else if (en) begin
            x.d = din; x.v = vin;
            hist.push_front(x);
            if (hist.size() > MD) void'(hist.pop_back());
            if (fill < MD) fill++;
        end
        #1;
    endtask

    function automatic logic [W-1:0] pat(input int n);
        logic [W-1:0] r;
        for (int c = 0; c < CH; c++) r[c*DW +: DW] = DW'(8'h10 * n + c);
        return r;
    endfunction

    initial begin
        // Reset state
        #3;
        check("rst_valid_out", W'(valid_out), '0);
        check("rst_primed", W'(primed), '0);
        check("rst_Data_Out", Data_Out, '0);
        #9 reset = 1'b1;
        @(posedge clk); #1;

        // Basic stream, delay 3
        for (int n = 0; n < 14; n++) step(1, 0, 1, pat(n), 3);

        // Stall: single sample A with delay 5, enable low for 4 cycles in the middle
        step(1, 1, 0, '0, 5);
        step(1, 0, 1, 32'hA5A5_A5A5, 5);
        step(1, 0, 0, pat(1), 5);
        for (int i = 0; i < 4; i++) step(0, 0, 0, pat(2), 5);
        for (int i = 0; i < 6; i++) step(1, 0, 0, pat(3 + i), 5);

        // Clamp: 0 behaves as 1, and 15 behaves as MAX_DELAY
        for (int n = 0; n < 4; n++) step(1, 0, 1, pat(n + 20), 0);
        step(1, 1, 0, '0, 15);
        for (int n = 0; n < 11; n++) step(1, 0, 1, pat(n + 30), 15);

        // Flush and enable together while the line is full
        step(1, 1, 1, 32'hDEAD_BEEF, 15);
        step(0, 0, 0, '0, 15);
        step(0, 0, 0, '0, 3);

        // Tap switch 6 -> 2 -> 6 while the stream is running
        for (int n = 0; n < 9; n++) step(1, 0, 1, pat(n + 40), 6);
        for (int n = 0; n < 3; n++) step(1, 0, 1, pat(n + 50), 2);
        for (int n = 0; n < 6; n++) step(1, 0, 1, pat(n + 60), 6);

        // Random traffic
        for (int n = 0; n < 400; n++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 1) != 0, $urandom(), $urandom_range(0, 15));

        // Asynchronous reset pulse between edges, mid-stream
        for (int n = 0; n < 8; n++) step(1, 0, 1, pat(n + 70), 4);
        enable = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("arst_valid_out", W'(valid_out), '0);
        check("arst_primed", W'(primed), '0);
        check("arst_Data_Out", Data_Out, '0);
        #2 reset = 1'b1;
        hist.delete();
        fill = 0;
        @(posedge clk); #1;
        for (int n = 0; n < 8; n++) step(1, 0, 1, pat(n + 80), 4);

        @(negedge clk); #1;
        check("scoreboard_drain", W'(exp_q.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
